gf_mult_seq: RTL and testbench
==============================

// Module: gf_mult_seq
// PURPOSE
//  Parametrised, handshaked GF(p) multiplier: radix-2 MSB-first interleaved double-and-add, one bit of b per clock.
//  Successor to the fixed 256-bit free-running multiplier: operands latched at start, explicit busy/done,
//  squaring mode, operand range checking, result held until next op. Feeds the EC point add/double sequencer.
// PARAMETERS
//  WIDTH    256                  operand/modulus width in bits (>=4)
//  CNT_W    $clog2(WIDTH)        bit-index counter width (derived, do not override)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      request; sampled only in IDLE
//  op_sq     in   1      1: compute a*a mod p (b ignored); 0: a*b mod p
//  a         in   WIDTH  multiplicand, unsigned, must be < p
//  b         in   WIDTH  multiplier, unsigned, must be < p
//  p         in   WIDTH  modulus, odd, unsigned
//  busy      out  1      high while an operation is in progress
//  done      out  1      one-cycle pulse: result/err valid
//  err       out  1      operand check failed for the op just completed
//  result    out  WIDTH  a*b mod p; held stable until next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, err=0, result=0, T=0, idx=0; internal operand regs cleared.
//  States: IDLE, RUN, FAIL.
//  IDLE: start=1 -> latch A=a, B=(op_sq ? a : b), P=p; T<=0; idx<=WIDTH-1; busy<=1.
//    If a>=p, (!op_sq && b>=p) or p[0]==0 -> FAIL, else -> RUN. start=0 -> stay, outputs hold.
//  RUN, each cycle: T <= step(T, A, B[idx], P); idx<=idx-1.
//    step: D = 2T mod P (one conditional subtract on WIDTH+1 bits);
//          T' = B[idx] ? (D+A mod P, one conditional subtract on WIDTH+1 bits) : D.
//    Invariant T<P held every cycle; no intermediate exceeds WIDTH+1 bits.
//    idx==0: result<=step(...), done<=1, err<=0, busy<=0, -> IDLE.
//  FAIL (one cycle): result<=0, err<=1, done<=1, busy<=0, -> IDLE.
//  Latency: start sampled on edge k -> done high in cycle after edge k+WIDTH (RUN) or k+2 (FAIL).
//  Throughput: back-to-back; start may be high in the cycle done is high (state already IDLE) and is accepted.
//  start while busy: ignored, no effect on operands or counter; no queueing.
//  Inputs a/b/p/op_sq are don't-care except in the start-accept cycle.
//  err valid with done; err/result hold until next accepted start; done is exactly one cycle.
//  Reset mid-RUN: immediate abort, all outputs return to reset values, no done pulse.
//  a==0 or b==0: full WIDTH cycles, result 0, err=0. p==1 is odd: a,b must be 0, result 0.
// STRUCTURE
//  Shared include gf_defs.vh: state localparams (IDLE/RUN/FAIL), default GF_WIDTH=256.
//  One sub-module gf_mod_step (combinational: T, A, b_i, P -> T'), reused by future radix-4 variant.
//  Top holds FSM, operand regs, idx down-counter, range compare, output regs.
// TESTING (WIDTH=8 unless noted; compare against big-int model)
//  1. p=251, a=200, b=100, op_sq=0 -> done 8 cycles after start, result=171, err=0.
//  2. p=251, a=250, op_sq=1, b=0xFF (ignored) -> result=1, err=0.
//  3. p=251, a=251, b=5 -> FAIL: done 2 cycles after start, err=1, result=0; next valid op clears err.
//  4. start held high through op 1, new a/b driven mid-run -> operands unchanged, result=171;
//     second op accepted in done cycle, completes 8 cycles later.
//  5. rst asserted at cycle 4 of RUN -> busy/done/err/result=0 immediately; no done pulse afterwards.
//  6. WIDTH=256, p=2^256-2^32-977, 1000 random a,b<p plus a=b=p-1 -> all results match model, latency 256.

Source files
------------

// File: rtl/gf_mult_seq_pkg.sv
// Shared types and defaults for the sequential GF(p) multiplier.
package gf_mult_seq_pkg;

    localparam int GF_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

endpackage

// File: rtl/gf_mult_seq_if.sv
// Request/response bundle between a GF(p) multiplier and its sequencer.
interface gf_mult_seq_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic             op_sq;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_sq, a, b, p,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op_sq, a, b, p,
        output busy, done, err, result
    );
endinterface

// File: rtl/gf_mult_seq_mod_step.sv
// One MSB-first double-and-add step: T' = (2T + b_i*A) mod P, given T,A < P.
// Purely combinational; every intermediate fits in WIDTH+1 bits.
module gf_mod_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] a,
    input  logic             b_i,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] t_nxt
);
    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_red;

    always_comb begin
        p_ext   = {1'b0, p};
        dbl     = {t, 1'b0};
        // T < P guarantees 2T < 2P, so one subtract restores the range
        dbl_red = WIDTH'((dbl >= p_ext) ? (dbl - p_ext) : dbl);
        sum     = {1'b0, dbl_red} + {1'b0, a};
        sum_red = WIDTH'((sum >= p_ext) ? (sum - p_ext) : sum);
        t_nxt   = b_i ? sum_red : dbl_red;
    end
endmodule

// File: rtl/gf_mult_seq.sv
// Handshaked GF(p) multiplier, one multiplier bit per clock: done WIDTH cycles after
// accept (2 on operand error); start is ignored while busy, result held until next op.
module gf_mult_seq
    import gf_mult_seq_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    gf_mult_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] t_step;
    logic             opnd_bad;

    gf_mod_step #(.WIDTH(WIDTH)) u_step (
        .t     (t_q),
        .a     (a_q),
        .b_i   (b_q[idx_q]),
        .p     (p_q),
        .t_nxt (t_step)
    );

    // Range check works on the latched operands so the wide compares stay off the
    // input path; it runs alongside the first step and diverts to FAIL if needed.
    // In squaring mode B holds a copy of A, so checking B is harmless.
    assign opnd_bad = (a_q >= p_q) || (b_q >= p_q) || !p_q[0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        t_d      = t_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.op_sq ? bus.a : bus.b;
                    p_d     = bus.p;
                    t_d     = '0;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((idx_q == IDX_TOP) && opnd_bad) begin
                    state_d = ST_FAIL;
                end else begin
                    t_d   = t_step;
                    idx_d = idx_q - 1'b1;
                    if (idx_q == '0) begin
                        result_d = t_step;
                        done_d   = 1'b1;
                        err_d    = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
                result_d = '0;
                err_d    = 1'b1;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            t_q      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            t_q      <= t_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed bench for gf_mult_seq at WIDTH=8 plus a WIDTH=256 instance on the secp256k1 prime.
module tb_gf_mult_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf_mult_seq_if #(.WIDTH(8))   i8();
    gf_mult_seq_if #(.WIDTH(256)) iw();

    gf_mult_seq #(.WIDTH(8))   dut8 (.clk(clk), .rst(rst), .bus(i8));
    gf_mult_seq #(.WIDTH(256)) dutw (.clk(clk), .rst(rst), .bus(iw));

    localparam logic [255:0] P256 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tp,
                        input logic sq, output logic [7:0] r, output logic e, output int lat);
        @(negedge clk);
        i8.start = 1'b1; i8.op_sq = sq; i8.a = ta; i8.b = tb_; i8.p = tp;
        @(negedge clk);
        i8.start = 1'b0;
        lat = 0;
        while (!i8.done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        r = i8.result;
        e = i8.err;
    endtask

    task automatic run256(input logic [255:0] ta, input logic [255:0] tb_,
                          output logic [255:0] r, output logic e, output int lat);
        @(negedge clk);
        iw.start = 1'b1; iw.op_sq = 1'b0; iw.a = ta; iw.b = tb_; iw.p = P256;
        @(negedge clk);
        iw.start = 1'b0;
        lat = 0;
        while (!iw.done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        r = iw.result;
        e = iw.err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (i8.busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got %b want 0", i8.busy); end
        vec_cnt++; if (i8.done !== 1'b0) begin miss_cnt++; $display("FAIL reset_done got %b want 0", i8.done); end
        vec_cnt++; if (i8.err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err got %b want 0", i8.err); end
        vec_cnt++; if (i8.result !== 8'd0) begin miss_cnt++; $display("FAIL reset_result got %0d want 0", i8.result); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] r; logic e; int lat;
        run8(8'd200, 8'd100, 8'd251, 1'b0, r, e, lat);
        vec_cnt++; if (r !== 8'd171) begin miss_cnt++; $display("FAIL basic_result got %0d want 171", r); end
        vec_cnt++; if (e !== 1'b0) begin miss_cnt++; $display("FAIL basic_err got %b want 0", e); end
        vec_cnt++; if (lat !== 8) begin miss_cnt++; $display("FAIL basic_latency got %0d want 8", lat); end
        repeat (3) @(negedge clk);
        vec_cnt++; if (i8.done !== 1'b0) begin miss_cnt++; $display("FAIL done_one_cycle got %b want 0", i8.done); end
        vec_cnt++; if (i8.result !== 8'd171) begin miss_cnt++; $display("FAIL result_hold got %0d want 171", i8.result); end
        run8(8'd3, 8'd5, 8'd7, 1'b0, r, e, lat);
        vec_cnt++; if (r !== 8'd1) begin miss_cnt++; $display("FAIL small_result got %0d want 1", r); end
        run8(8'd0, 8'd77, 8'd251, 1'b0, r, e, lat);
        vec_cnt++; if (r !== 8'd0 || e !== 1'b0) begin miss_cnt++; $display("FAIL zero_a got %0d/%b want 0/0", r, e); end
        vec_cnt++; if (lat !== 8) begin miss_cnt++; $display("FAIL zero_a_latency got %0d want 8", lat); end
        run8(8'd0, 8'd0, 8'd1, 1'b0, r, e, lat);
        vec_cnt++; if (r !== 8'd0 || e !== 1'b0) begin miss_cnt++; $display("FAIL p_one got %0d/%b want 0/0", r, e); end
    endtask

    task automatic test_square();
        logic [7:0] r; logic e; int lat;
        run8(8'd250, 8'hFF, 8'd251, 1'b1, r, e, lat);
        vec_cnt++; if (r !== 8'd1 || e !== 1'b0) begin miss_cnt++; $display("FAIL square_250 got %0d/%b want 1/0", r, e); end
        run8(8'd5, 8'd255, 8'd251, 1'b1, r, e, lat);
        vec_cnt++; if (r !== 8'd25 || e !== 1'b0) begin miss_cnt++; $display("FAIL square_b_ignored got %0d/%b want 25/0", r, e); end
    endtask

    task automatic test_fail();
        logic [7:0] r; logic e; int lat;
        run8(8'd251, 8'd5, 8'd251, 1'b0, r, e, lat);
        vec_cnt++; if (e !== 1'b1 || r !== 8'd0) begin miss_cnt++; $display("FAIL a_range got %0d/%b want 0/1", r, e); end
        vec_cnt++; if (lat !== 2) begin miss_cnt++; $display("FAIL fail_latency got %0d want 2", lat); end
        run8(8'd3, 8'd5, 8'd7, 1'b0, r, e, lat);
        vec_cnt++; if (e !== 1'b0 || r !== 8'd1) begin miss_cnt++; $display("FAIL err_clear got %0d/%b want 1/0", r, e); end
        run8(8'd5, 8'd251, 8'd251, 1'b0, r, e, lat);
        vec_cnt++; if (e !== 1'b1) begin miss_cnt++; $display("FAIL b_range got %b want 1", e); end
        run8(8'd1, 8'd1, 8'd250, 1'b0, r, e, lat);
        vec_cnt++; if (e !== 1'b1) begin miss_cnt++; $display("FAIL even_p got %b want 1", e); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        i8.start = 1'b1; i8.op_sq = 1'b0; i8.a = 8'd200; i8.b = 8'd100; i8.p = 8'd251;
        @(negedge clk);
        i8.a = 8'd7; i8.b = 8'd9;
        n = 0;
        while (!i8.done && n < 40) begin @(negedge clk); n++; end
        vec_cnt++; if (n !== 8 || i8.result !== 8'd171) begin miss_cnt++; $display("FAIL b2b_first got %0d@%0d want 171@8", i8.result, n); end
        @(negedge clk);
        i8.start = 1'b0;
        vec_cnt++; if (i8.done !== 1'b0 || i8.busy !== 1'b1) begin miss_cnt++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1", i8.done, i8.busy); end
        n = 0;
        while (!i8.done && n < 40) begin @(negedge clk); n++; end
        vec_cnt++; if (n !== 8 || i8.result !== 8'd63) begin miss_cnt++; $display("FAIL b2b_second got %0d@%0d want 63@8", i8.result, n); end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'd3; i8.b = 8'd5; i8.p = 8'd7; i8.op_sq = 1'b0;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.err !== 1'b0 || i8.result !== 8'd0) begin
            miss_cnt++;
            $display("FAIL midrun_reset got busy=%b done=%b err=%b result=%0d want all 0", i8.busy, i8.done, i8.err, i8.result);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (i8.done) seen = 1'b1; end
        vec_cnt++; if (seen !== 1'b0 || i8.busy !== 1'b0) begin miss_cnt++; $display("FAIL midrun_no_done got seen=%b busy=%b want 0/0", seen, i8.busy); end
    endtask

    task automatic test_wide();
        logic [255:0] r, ra, rb, expv;
        logic [511:0] prod;
        logic e; int lat;
        run256(P256 - 256'd1, P256 - 256'd1, r, e, lat);
        vec_cnt++; if (r !== 256'd1 || e !== 1'b0) begin miss_cnt++; $display("FAIL wide_pm1 got %h/%b want 1/0", r, e); end
        vec_cnt++; if (lat !== 256) begin miss_cnt++; $display("FAIL wide_latency got %0d want 256", lat); end
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 8; k++) begin
                ra[k*32 +: 32] = $urandom;
                rb[k*32 +: 32] = $urandom;
            end
            ra = ra % P256;
            rb = rb % P256;
            prod = {256'd0, ra} * {256'd0, rb};
            expv = 256'(prod % {256'd0, P256});
            run256(ra, rb, r, e, lat);
            vec_cnt++; if (r !== expv || e !== 1'b0 || lat !== 256) begin
                miss_cnt++;
                $display("FAIL wide_rand%0d got %h err=%b lat=%0d want %h err=0 lat=256", v, r, e, lat, expv);
            end
        end
    endtask

    initial begin
        i8.start = 1'b0; i8.op_sq = 1'b0; i8.a = '0; i8.b = '0; i8.p = '0;
        iw.start = 1'b0; iw.op_sq = 1'b0; iw.a = '0; iw.b = '0; iw.p = '0;
        test_reset();
        test_basic();
        test_square();
        test_fail();
        test_back_to_back();
        test_reset_midrun();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
